// File: rtl/stage_pipe_reg_pkg.sv
// Shared types for the write-back stage register.
// The packet struct is sized for the largest supported configuration;
// instances narrower than that leave the upper bits at zero.
package project_types;

    localparam int PKT_NPORT_MAX  = 4;
    localparam int PKT_ADDR_W_MAX = 8;
    localparam int PKT_DATA_W_MAX = 64;

    // One write-back packet: GPR channels plus the HI/LO pair.
    typedef struct packed {
        logic [PKT_NPORT_MAX-1:0]                     we;
        logic [PKT_NPORT_MAX-1:0][PKT_ADDR_W_MAX-1:0] addr;
        logic [PKT_NPORT_MAX-1:0][PKT_DATA_W_MAX-1:0] data;
        logic                                         hilo_we;
        logic [PKT_DATA_W_MAX-1:0]                    hi;
        logic [PKT_DATA_W_MAX-1:0]                    lo;
    } stage_pkt_t;

    localparam stage_pkt_t STAGE_PKT_ZERO = '0;

    // Occupancy of the stage: nothing held, main slot held, main + skid held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/stage_pipe_reg_slot.sv
// pipe_slot: a single packet register with synchronous clear and load.
// Clear has priority over load so a reset in the same cycle as a load
// leaves the slot zeroed.
module pipe_slot
    import project_types::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       ld,
    input  stage_pkt_t d,
    output stage_pkt_t q
);

    // Packet storage: clear wins, otherwise capture on load, else hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= STAGE_PKT_ZERO;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/stage_pipe_reg.sv
// stage_pipe_reg: valid/ready pipeline register for the GPR + HI/LO
// write-back packet.
// Build option: define STAGE_PIPE_SKID_EN for a two-entry skid buffer with a
// registered in_ready; leave it undefined for a single slot whose in_ready is
// out_ready | ~out_valid.
module stage_pipe_reg
    import project_types::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NPORT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NPORT-1:0]        in_we,
    input  logic [NPORT*ADDR_W-1:0] in_addr,
    input  logic [NPORT*DATA_W-1:0] in_data,
    input  logic                    in_hilo_we,
    input  logic [DATA_W-1:0]       in_hi,
    input  logic [DATA_W-1:0]       in_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NPORT-1:0]        out_we,
    output logic [NPORT*ADDR_W-1:0] out_addr,
    output logic [NPORT*DATA_W-1:0] out_data,
    output logic                    out_hilo_we,
    output logic [DATA_W-1:0]       out_hi,
    output logic [DATA_W-1:0]       out_lo
);

    if (NPORT < 1 || NPORT > PKT_NPORT_MAX) begin : g_bad_nport
        $error("stage_pipe_reg: NPORT out of range");
    end
    if (ADDR_W < 1 || ADDR_W > PKT_ADDR_W_MAX) begin : g_bad_addr_w
        $error("stage_pipe_reg: ADDR_W out of range");
    end
    if (DATA_W < 1 || DATA_W > PKT_DATA_W_MAX) begin : g_bad_data_w
        $error("stage_pipe_reg: DATA_W out of range");
    end

    pipe_state_t state_p1;
    pipe_state_t state_n;
    stage_pkt_t  in_pkt;
    stage_pkt_t  main_d;
    stage_pkt_t  pkt_p1;
    logic        main_ld;
    logic        vld_p1;
    logic        in_fire;
    logic        out_fire;
    logic        unused_pkt;

    assign vld_p1   = (state_p1 != ST_EMPTY);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = vld_p1 & out_ready;

    // Widen the flat input ports into the packet struct.
    always_comb begin
        in_pkt         = STAGE_PKT_ZERO;
        in_pkt.hilo_we = in_hilo_we;
        in_pkt.hi      = PKT_DATA_W_MAX'(in_hi);
        in_pkt.lo      = PKT_DATA_W_MAX'(in_lo);
        for (int p = 0; p < NPORT; p++) begin
            in_pkt.we[p]   = in_we[p];
            in_pkt.addr[p] = PKT_ADDR_W_MAX'(in_addr[p*ADDR_W +: ADDR_W]);
            in_pkt.data[p] = PKT_DATA_W_MAX'(in_data[p*DATA_W +: DATA_W]);
        end
    end

`ifdef STAGE_PIPE_SKID_EN
    stage_pkt_t skid_p1;
    logic       skid_ld;
    logic       main_from_skid;
    logic       in_ready_p1;

    // Occupancy transitions; flush empties the stage and drops the input.
    always_comb begin
        state_n        = state_p1;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_n = ST_EMPTY;
        end else begin
            case (state_p1)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_n = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_n = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_n        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_p1 : in_pkt;

    // in_ready is registered: it drops only while both slots are occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_p1 <= 1'b1;
        end else begin
            in_ready_p1 <= (state_n != ST_TWO);
        end
    end

    assign in_ready = in_ready_p1;

    pipe_slot u_skid (
        .clk (clk),
        .clr (rst),
        .ld  (skid_ld),
        .d   (in_pkt),
        .q   (skid_p1)
    );
`else
    // Single-slot transitions; a new packet may replace the one leaving.
    always_comb begin
        state_n = state_p1;
        main_ld = 1'b0;
        if (flush) begin
            state_n = ST_EMPTY;
        end else begin
            case (state_p1)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_n = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire) begin
                        main_ld = 1'b1;
                    end else if (out_fire) begin
                        state_n = ST_EMPTY;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    assign main_d   = in_pkt;
    assign in_ready = out_ready | ~vld_p1;
`endif

    // Occupancy register; reset takes priority over flush and transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= ST_EMPTY;
        end else begin
            state_p1 <= state_n;
        end
    end

    pipe_slot u_main (
        .clk (clk),
        .clr (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (pkt_p1)
    );

    // Narrow the held packet onto the ports; enables are gated by valid.
    always_comb begin
        out_addr = '0;
        out_data = '0;
        for (int p = 0; p < NPORT; p++) begin
            out_addr[p*ADDR_W +: ADDR_W] = pkt_p1.addr[p][ADDR_W-1:0];
            out_data[p*DATA_W +: DATA_W] = pkt_p1.data[p][DATA_W-1:0];
        end
    end

    assign out_valid   = vld_p1;
    assign out_we      = pkt_p1.we[NPORT-1:0] & {NPORT{vld_p1}};
    assign out_hilo_we = pkt_p1.hilo_we & vld_p1;
    assign out_hi      = pkt_p1.hi[DATA_W-1:0];
    assign out_lo      = pkt_p1.lo[DATA_W-1:0];

    // Upper struct bits beyond the configured widths stay zero and are not read.
    assign unused_pkt = ^pkt_p1;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Testbench for stage_pipe_reg (NPORT=2). Expected packets are queued when
// the bench sees an input transfer and compared while held on the output.
// Works with STAGE_PIPE_SKID_EN either defined or undefined.
module tb_stage_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
`ifdef STAGE_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic [NP-1:0]    we;
        logic [NP*AW-1:0] addr;
        logic [NP*DW-1:0] data;
        logic             hwe;
        logic [DW-1:0]    hi;
        logic [DW-1:0]    lo;
    } pkt_t;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [NP-1:0]    in_we, out_we;
    logic [NP*AW-1:0] in_addr, out_addr;
    logic [NP*DW-1:0] in_data, out_data;
    logic             in_hilo_we, out_hilo_we;
    logic [DW-1:0]    in_hi, in_lo, out_hi, out_lo;

    int   total = 0;
    int   bad   = 0;
    pkt_t sb[$];
    logic fired;

    stage_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .NPORT(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_hilo_we (in_hilo_we),
        .in_hi      (in_hi),
        .in_lo      (in_lo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_hilo_we(out_hilo_we),
        .out_hi     (out_hi),
        .out_lo     (out_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [NP-1:0] we, input logic [NP*AW-1:0] addr,
                         input logic [NP*DW-1:0] data, input logic hwe,
                         input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        in_valid   = v;
        in_we      = we;
        in_addr    = addr;
        in_data    = data;
        in_hilo_we = hwe;
        in_hi      = hi;
        in_lo      = lo;
    endtask

    task automatic idle_in();
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    // One clock: check outputs against the model at negedge, advance the
    // model with this cycle's inputs, then return just after the rising edge.
    task automatic cyc();
        logic rdy_m;
        pkt_t f;
        pkt_t n;
        @(negedge clk);
        fired = 1'b0;
        if (rst) begin
            sb.delete();
        end else begin
            rdy_m = SKID ? (sb.size() < 2) : (out_ready || sb.size() == 0);
            chk("in_ready", 64'(in_ready), 64'(rdy_m));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (!out_valid) chk("en_gate", 64'({out_hilo_we, out_we}), 64'd0);
            if (sb.size() != 0) begin
                f = sb[0];
                chk("data", 64'(out_data), 64'(f.data));
                chk("addr", 64'(out_addr), 64'(f.addr));
                chk("we", 64'(out_we), 64'(f.we));
                chk("hilo_we", 64'(out_hilo_we), 64'(f.hwe));
                chk("hi", 64'(out_hi), 64'(f.hi));
                chk("lo", 64'(out_lo), 64'(f.lo));
            end
            fired = in_valid && rdy_m;
            if (flush) begin
                sb.delete();
            end else begin
                if (sb.size() != 0 && out_ready) void'(sb.pop_front());
                if (fired) begin
                    n.we = in_we; n.addr = in_addr; n.data = in_data;
                    n.hwe = in_hilo_we; n.hi = in_hi; n.lo = in_lo;
                    sb.push_back(n);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_we"}, 64'(out_we), 64'd0);
        chk({tag, "_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_hwe"}, 64'(out_hilo_we), 64'd0);
        chk({tag, "_hi"}, 64'(out_hi), 64'd0);
        chk({tag, "_lo"}, 64'(out_lo), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int k;
        logic [NP*DW-1:0] bp_data [3];
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle_in();
        #1;
        cyc();
        rst = 1'b0;
        check_zero("reset");

        // Streaming: eight back-to-back packets, data 1..8 on channel 0.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'(i), {5'(i + 1), 5'(i)}, {32'(i + 100), 32'(i)}, 1'(i),
                  32'(i * 3), 32'(i * 5));
            cyc();
            chk("stream_rdy", 64'(in_ready), 64'd1);
            chk("stream_data", 64'(out_data[DW-1:0]), 64'(i));
        end
        idle_in();
        cyc();
        cyc();

        // Backpressure: A,B,C offered while downstream stalls, then released.
        bp_data[0] = 64'h0A0A; bp_data[1] = 64'h0B0B; bp_data[2] = 64'h0C0C;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 30 && (k < 3 || sb.size() != 0); c++) begin
            if (c == 5) out_ready = 1'b1;
            if (k < 3) drive(1'b1, 2'b01, 10'(k + 1), bp_data[k], 1'b0, '0, '0);
            else idle_in();
            cyc();
            if (fired) k++;
        end
        chk("bp_sent", 64'(k), 64'd3);
        chk("bp_drained", 64'(sb.size()), 64'd0);
        idle_in();
        cyc();

        // Flush while full with a 0x55 packet offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 10'h21, 64'h1111, 1'b1, 32'h1, 32'h2);
        cyc();
        drive(1'b1, 2'b01, 10'h22, 64'h2222, 1'b0, 32'h3, 32'h4);
        cyc();
`ifdef STAGE_PIPE_SKID_EN
        chk("two_rdy", 64'(in_ready), 64'd0);
`endif
        flush = 1'b1;
        drive(1'b1, 2'b11, 10'h3FF, 64'h55, 1'b1, 32'h55, 32'h55);
        cyc();
        flush = 1'b0;
        idle_in();
        chk("flush_vld", 64'(out_valid), 64'd0);
        chk("flush_we", 64'(out_we), 64'd0);
        chk("flush_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no55", 64'(out_valid && out_data == 64'h55), 64'd0);
        end

        // Two channels: only channel 1 enabled.
        drive(1'b1, 2'b10, {5'd3, 5'd7}, {32'h11, 32'h22}, 1'b0, '0, '0);
        cyc();
        idle_in();
        chk("np2_vld", 64'(out_valid), 64'd1);
        chk("np2_we", 64'(out_we), 64'h2);
        chk("np2_addr", 64'(out_addr), 64'(10'b00011_00111));
        chk("np2_data", 64'(out_data), 64'h0000_0011_0000_0022);
        cyc();
        chk("np2_we_off", 64'(out_we), 64'd0);

`ifndef STAGE_PIPE_SKID_EN
        // Single slot: stall blocks input combinationally; release replaces.
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 10'h5, 64'h0AA, 1'b0, '0, '0);
        cyc();
        drive(1'b1, 2'b01, 10'h6, 64'h0BB, 1'b0, '0, '0);
        #1;
        chk("ns_rdy0", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("ns_rdy1", 64'(in_ready), 64'd1);
        cyc();
        idle_in();
        chk("ns_repl", 64'(out_data), 64'h0BB);
        cyc();
`endif

        // Random traffic with bubbles and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(0, 30) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0)
                drive(1'b1, 2'($urandom_range(0, 3)), 10'($urandom), {$urandom, $urandom},
                      1'($urandom_range(0, 1)), $urandom, $urandom);
            else
                idle_in();
            cyc();
        end
        flush = 1'b0;

        // Reset while holding packets drops everything.
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 10'h1F, 64'h77, 1'b1, 32'h9, 32'h8);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle_in();
        check_zero("rst_mid");
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_pipe_reg.md
STAGE_PIPE_REG -- requirements
Module: stage_pipe_reg

Interface
REQ-001 Parameter DATA_W, 32, width of each data word and of HI and LO.
REQ-002 Parameter ADDR_W, 5, register-file address width.
REQ-003 Parameter NPORT, 1, number of GPR write-back channels carried (range 1..4).
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discard all held packets (exception/branch squash).
REQ-007 in_valid  in  1  upstream packet present.
REQ-008 in_ready  out  1  block accepts a packet this cycle.
REQ-009 in_we  in  NPORT  per-channel GPR write enable.
REQ-010 in_addr  in  NPORT x ADDR_W  per-channel destination register.
REQ-011 in_data  in  NPORT x DATA_W  per-channel write data.
REQ-012 in_hilo_we  in  1  HI/LO write enable.
REQ-013 in_hi, in_lo  in  DATA_W each  HI/LO values.
REQ-014 out_valid  out  1  downstream packet present.
REQ-015 out_ready  in  1  downstream consumes packet this cycle.
REQ-016 out_we, out_addr, out_data, out_hilo_we, out_hi, out_lo  out  widths mirror inputs  held packet.

Function
REQ-017 Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-018 Latency: a packet accepted in cycle N is presented on out_* in cycle N+1 when the block was empty.
REQ-019 Packets leave in acceptance order; none duplicated or dropped except by flush/rst.
REQ-020 out_we and out_hilo_we are forced to 0 whenever out_valid is 0; other out_* hold the last value.
REQ-021 With the skid buffer (see REQ-027), states are EMPTY, ONE (main slot full), TWO (main + skid full).
REQ-022 EMPTY: in transfer -> ONE. ONE: in only -> TWO (packet into skid); out only -> EMPTY; both -> ONE (main replaced). TWO: out transfer -> ONE (skid moves to main); in_ready is 0.
REQ-023 in_ready is a registered output: 1 in EMPTY and ONE, 0 in TWO.
REQ-024 flush wins over any simultaneous transfer: next state EMPTY, out_valid 0, the same-cycle input packet discarded, in_ready 1 next cycle.
REQ-025 A packet with all enables 0 and in_valid 1 is a legal bubble and travels as a normal packet.

Reset
REQ-026 rst (priority over flush) in a cycle -> next cycle: state EMPTY, out_valid 0, out_we 0, out_addr 0, out_data 0, out_hilo_we 0, out_hi 0, out_lo 0, in_ready 1; reset mid-transfer drops all held packets.

Configuration
REQ-027 Macro STAGE_PIPE_SKID_EN: defined -> two-entry skid behaviour of REQ-021..023; undefined -> single slot, in_ready = out_ready | ~out_valid (combinational), states EMPTY/ONE only, REQ-018..020, 024, 026 unchanged.

Structure
REQ-028 project_types package holds the stage packet struct (we/addr/data arrays, hilo fields), its zero constant, and the enum for EMPTY/ONE/TWO.
REQ-029 One sub-module, pipe_slot: one packet register with load and clear, instantiated twice (main, skid) or once without the macro.

Verification
REQ-030 Reset: assert rst 1 cycle with out_ready 0 -> out_valid 0, all out_* 0, in_ready 1.
REQ-031 Stream: in_valid 1 for 8 cycles, data 1..8, out_ready 1 -> out_data 1..8 in cycles N+1..N+8, in_ready stays 1.
REQ-032 Backpressure (macro on): send A,B,C with out_ready 0 -> in_ready 0 after B; C held upstream; raise out_ready -> A,B,C emitted in order, no loss.
REQ-033 Flush in TWO state with in_valid 1 (data 0x55) -> next cycle out_valid 0, out_we 0, 0x55 never appears.
REQ-034 NPORT=2: in_we=2'b10, addr {5'd3,5'd7}, data {0x11,0x22} -> output the same one cycle later; then out_valid 0 -> out_we 0.
REQ-035 Macro off: out_valid 1, out_ready 0 -> in_ready 0 same cycle; out_ready 1 with new in_valid -> packet replaced in one cycle.
